// File: rtl/histogram_ram_ctrl_pkg.sv
// Shared types and default sizes for the histogram RAM controller.
// The FSM state encoding lives here so the top and any checkers agree on it.
package histogram_ram_ctrl_pkg;

  localparam int BIN_W_DEF = 10;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_READOUT = 3'd4
  } state_t;

endpackage

// File: rtl/histogram_ram_ctrl_rmw.sv
// Read-modify-write pipeline for histogram accumulation: S0 captures the bin being read,
// S1 adds one (saturating) and writes back, forwarding its own last result to cover same-edge RAM hazards.
module histogram_ram_ctrl_rmw
  import histogram_ram_ctrl_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_acc,
  input  logic [BIN_W-1:0] i_bin,
  input  logic [CNT_W-1:0] i_q,
  output logic             o_we,
  output logic [BIN_W-1:0] o_addr,
  output logic [CNT_W-1:0] o_data,
  output logic             o_sat
);

  logic             r_a_vld;
  logic [BIN_W-1:0] r_a_bin;
  logic             r_b_vld;
  logic [BIN_W-1:0] r_b_bin;
  logic [CNT_W-1:0] r_b_data;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_sum;
  logic             w_clamp;

  // Returns {clamped, value+1}; a full counter stays at its maximum.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] res;
    if (&v) begin
      res = {1'b1, v};
    end else begin
      res = {1'b0, v + {{(CNT_W-1){1'b0}}, 1'b1}};
    end
    return res;
  endfunction

  // The RAM returns stale data when S1 wrote the same bin on the edge that launched this read.
  always_comb begin
    w_base = i_q;
    if (r_b_vld && (r_b_bin == r_a_bin)) begin
      w_base = r_b_data;
    end else begin
      w_base = i_q;
    end
    {w_clamp, w_sum} = sat_inc(w_base);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_vld  <= 1'b0;
      r_a_bin  <= '0;
      r_b_vld  <= 1'b0;
      r_b_bin  <= '0;
      r_b_data <= '0;
    end else begin
      r_a_vld <= i_acc;
      if (i_acc) begin
        r_a_bin <= i_bin;
      end
      r_b_vld  <= i_flush ? 1'b0 : r_a_vld;
      r_b_bin  <= r_a_bin;
      r_b_data <= w_sum;
    end
  end

  assign o_we   = r_a_vld;
  assign o_addr = r_a_bin;
  assign o_data = w_sum;
  assign o_sat  = r_a_vld & w_clamp;

endmodule

// File: rtl/soft_ram_dp.sv
// Behavioural simple dual-port RAM with one registered read port; a shared clock enable
// gates both the write and the Q update. Same-address read/write returns the old word.
module soft_ram_dp #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_ce,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_ce) begin
      if (i_we) begin
        r_mem[i_wr_addr] <= i_wr_data;
      end
      o_q <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/histogram_ram_ctrl.sv
// Per-frame sequencer for the histogram RAM: clear every bin, accumulate pixels through the
// RMW pipeline, drain it, then stream all bins out in order under valid/ready flow control.
module histogram_ram_ctrl
  import histogram_ram_ctrl_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             pix_valid,
  input  logic [BIN_W-1:0] pix_bin,
  output logic             pix_ready,
  output logic [BIN_W-1:0] ram_wr_addr,
  output logic [CNT_W-1:0] ram_wr_data,
  output logic             ram_we,
  output logic             ram_ce,
  output logic [BIN_W-1:0] ram_rd_addr,
  input  logic [CNT_W-1:0] ram_q,
  output logic [CNT_W-1:0] hist_data,
  output logic [BIN_W-1:0] hist_bin,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic             hist_last,
  output logic             busy,
  output logic             sat_flag
);

  localparam logic [BIN_W-1:0] LAST_BIN = {BIN_W{1'b1}};
  localparam logic [BIN_W-1:0] ONE_BIN  = {{(BIN_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [BIN_W-1:0] r_ptr;
  logic             r_drain_cnt;
  logic             r_rd_done;
  logic             r_q_vld;
  logic [BIN_W-1:0] r_hist_bin;
  logic             r_sat;

  logic             w_accept;
  logic             w_drain_exit;
  logic             w_rd_ce;
  logic             w_last_hs;
  logic             w_pipe_we;
  logic [BIN_W-1:0] w_pipe_addr;
  logic [CNT_W-1:0] w_pipe_data;
  logic             w_pipe_sat;

  assign w_accept     = pix_valid && (r_state == ST_ACCUM);
  assign w_drain_exit = (r_state == ST_DRAIN) && r_drain_cnt;
  // A beat stalled at the output freezes the RAM so Q keeps presenting it.
  assign w_rd_ce      = !(r_q_vld && !hist_ready);
  assign w_last_hs    = hist_last && hist_ready;

  histogram_ram_ctrl_rmw #(
    .BIN_W (BIN_W),
    .CNT_W (CNT_W)
  ) u_rmw (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_drain_exit),
    .i_acc   (w_accept),
    .i_bin   (pix_bin),
    .i_q     (ram_q),
    .o_we    (w_pipe_we),
    .o_addr  (w_pipe_addr),
    .o_data  (w_pipe_data),
    .o_sat   (w_pipe_sat)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (frame_start) w_next_state = ST_CLEAR;   else w_next_state = ST_IDLE;
      ST_CLEAR:   if (r_ptr == LAST_BIN) w_next_state = ST_ACCUM; else w_next_state = ST_CLEAR;
      ST_ACCUM:   if (frame_end) w_next_state = ST_DRAIN;     else w_next_state = ST_ACCUM;
      ST_DRAIN:   if (r_drain_cnt) w_next_state = ST_READOUT; else w_next_state = ST_DRAIN;
      ST_READOUT: if (w_last_hs) w_next_state = ST_IDLE;      else w_next_state = ST_READOUT;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_ce      = 1'b0;
    ram_we      = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    ram_rd_addr = '0;
    case (r_state)
      ST_CLEAR: begin
        ram_ce      = 1'b1;
        ram_we      = 1'b1;
        ram_wr_addr = r_ptr;
      end
      ST_ACCUM, ST_DRAIN: begin
        ram_ce      = 1'b1;
        ram_we      = w_pipe_we;
        ram_wr_addr = w_pipe_addr;
        ram_wr_data = w_pipe_data;
        ram_rd_addr = pix_bin;
      end
      ST_READOUT: begin
        ram_ce      = w_rd_ce;
        ram_rd_addr = r_ptr;
      end
      default: begin
        ram_ce = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_drain_cnt <= 1'b0;
      r_rd_done   <= 1'b0;
      r_q_vld     <= 1'b0;
      r_hist_bin  <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= (r_state == ST_DRAIN);
      if (w_pipe_sat) begin
        r_sat <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_sat <= 1'b0;
            r_ptr <= '0;
          end
        end
        ST_CLEAR: r_ptr <= r_ptr + ONE_BIN;
        ST_DRAIN: begin
          r_ptr     <= '0;
          r_rd_done <= 1'b0;
          r_q_vld   <= 1'b0;
        end
        // r_rd_done marks that the final address has been issued.
        ST_READOUT: begin
          if (w_rd_ce) begin
            if (!r_rd_done) begin
              r_q_vld    <= 1'b1;
              r_hist_bin <= r_ptr;
              r_ptr      <= r_ptr + ONE_BIN;
              r_rd_done  <= (r_ptr == LAST_BIN);
            end else begin
              r_q_vld <= 1'b0;
            end
          end
        end
        default: r_ptr <= r_ptr;
      endcase
    end
  end

  assign pix_ready  = (r_state == ST_ACCUM);
  assign busy       = (r_state != ST_IDLE);
  assign sat_flag   = r_sat;
  assign hist_valid = r_q_vld;
  assign hist_bin   = r_hist_bin;
  assign hist_data  = r_q_vld ? ram_q : '0;
  assign hist_last  = r_q_vld && (r_hist_bin == LAST_BIN);

endmodule
